// File: rtl/note_lane_scroller_pkg.sv
// Shared game constants for the note lane scroller: default geometry and FSM state encodings.
package note_lane_scroller_pkg;

  localparam int unsigned DEF_LANE_LEN   = 16;
  localparam int unsigned DEF_SONG_STEPS = 64;
  localparam int unsigned DEF_SCORE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DONE = 2'b10
  } game_state_e;

endpackage

// File: rtl/note_lane_scroller_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector. The pulse is only armed once the
// synchronized input has been seen low, so a level already high at reset release is ignored.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic pulse_c_o
);

  logic s1_q, s2_q, prev_q;
  logic vld1_q, vld2_q;
  logic armed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= d_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      vld1_q  <= 1'b1;
      vld2_q  <= vld1_q;
      // s2_q only carries a real input sample once vld2_q is set
      armed_q <= armed_q | (vld2_q & ~s2_q);
    end
  end

  assign pulse_c_o = armed_q & s2_q & ~prev_q;

endmodule

// File: rtl/note_lane_scroller.sv
// Rhythm-game note lane: notes scroll toward the hit zone on each beat step, the player's
// key press scores hits, and a three-state FSM sequences one song.
module note_lane_scroller
  import note_lane_scroller_pkg::*;
#(
  parameter int unsigned LANE_LEN   = DEF_LANE_LEN,
  parameter int unsigned SONG_STEPS = DEF_SONG_STEPS,
  parameter int unsigned SCORE_W    = DEF_SCORE_W
) (
  input  logic                in_clock,
  input  logic                resetn,
  input  logic                beat_clk,
  input  logic                start,
  input  logic                note_in,
  input  logic                key_raw,
  output logic [LANE_LEN-1:0] lane,
  output logic                hit,
  output logic                miss,
  output logic [SCORE_W-1:0]  score,
  output logic [SCORE_W-1:0]  combo,
  output logic [1:0]          state
);

  localparam int unsigned          CNT_W     = $clog2(SONG_STEPS + 1);
  localparam logic [CNT_W-1:0]     LAST_STEP = CNT_W'(SONG_STEPS - 1);
  localparam logic [SCORE_W-1:0]   SCORE_MAX = '1;

  game_state_e          state_q, state_d;
  logic [LANE_LEN-1:0]  lane_q, lane_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   combo_q, combo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [LANE_LEN-1:0]  lane_hz;
  logic                 step_c;
  logic                 key_edge_c;

  sync_edge u_beat_sync (
    .clk_i     (in_clock),
    .rst_ni    (resetn),
    .d_i       (beat_clk),
    .pulse_c_o (step_c)
  );

  sync_edge u_key_sync (
    .clk_i     (in_clock),
    .rst_ni    (resetn),
    .d_i       (key_raw),
    .pulse_c_o (key_edge_c)
  );

  always_ff @(posedge in_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      score_q <= '0;
      combo_q <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      score_q <= score_d;
      combo_q <= combo_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Key is judged against the pre-shift hit zone; lane_hz is the lane after any hit clears bit 0
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    score_d = score_q;
    combo_d = combo_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    lane_hz = lane_q;

    case (state_q)
      ST_IDLE: begin
        lane_d  = '0;
        score_d = '0;
        combo_d = '0;
        cnt_d   = '0;
        if (start) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (key_edge_c) begin
          if (lane_q[0]) begin
            hit_d      = 1'b1;
            lane_hz[0] = 1'b0;
            if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
            if (combo_q != SCORE_MAX) combo_d = combo_q + 1'b1;
          end else begin
            miss_d  = 1'b1;
            combo_d = '0;
          end
        end
        if (step_c) begin
          if (lane_hz[0]) begin
            miss_d  = 1'b1;
            combo_d = '0;
          end
          lane_d = LANE_LEN'({note_in, lane_hz} >> 1);
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_d = ST_DONE;
          end
        end else begin
          lane_d = lane_hz;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d = ST_IDLE;
          lane_d  = '0;
          score_d = '0;
          combo_d = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign lane  = lane_q;
  assign hit   = hit_q;
  assign miss  = miss_q;
  assign score = score_q;
  assign combo = combo_q;
  assign state = state_q;

endmodule

// File: tb/tb_note_lane_scroller.sv
// Scoreboard bench for note_lane_scroller: three instances cover the default lane,
// a narrow saturating score, and a short song.
module tb_note_lane_scroller;

  logic clk = 1'b0;
  logic resetn;
  logic beat [3];
  logic strt [3];
  logic note [3];
  logic key  [3];

  logic [15:0] a_lane;
  logic        a_hit, a_miss;
  logic [7:0]  a_score, a_combo;
  logic [1:0]  a_state;

  logic [1:0]  b_lane;
  logic        b_hit, b_miss;
  logic [1:0]  b_score, b_combo;
  logic [1:0]  b_state;

  logic [3:0]  c_lane;
  logic        c_hit, c_miss;
  logic [7:0]  c_score, c_combo;
  logic [1:0]  c_state;

  typedef struct {
    int    inst;
    bit    is_hit;
    int    score;
    int    combo;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  note_lane_scroller u_a (
    .in_clock (clk), .resetn (resetn), .beat_clk (beat[0]), .start (strt[0]),
    .note_in (note[0]), .key_raw (key[0]), .lane (a_lane), .hit (a_hit),
    .miss (a_miss), .score (a_score), .combo (a_combo), .state (a_state)
  );

  note_lane_scroller #(.LANE_LEN(2), .SONG_STEPS(16), .SCORE_W(2)) u_b (
    .in_clock (clk), .resetn (resetn), .beat_clk (beat[1]), .start (strt[1]),
    .note_in (note[1]), .key_raw (key[1]), .lane (b_lane), .hit (b_hit),
    .miss (b_miss), .score (b_score), .combo (b_combo), .state (b_state)
  );

  note_lane_scroller #(.LANE_LEN(4), .SONG_STEPS(4), .SCORE_W(8)) u_c (
    .in_clock (clk), .resetn (resetn), .beat_clk (beat[2]), .start (strt[2]),
    .note_in (note[2]), .key_raw (key[2]), .lane (c_lane), .hit (c_hit),
    .miss (c_miss), .score (c_score), .combo (c_combo), .state (c_state)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  function automatic void expect_evt(int inst, bit is_hit, int score, int combo, string tag);
    exp_t e;
    e.inst = inst; e.is_hit = is_hit; e.score = score; e.combo = combo; e.tag = tag;
    exp_q.push_back(e);
  endfunction

  function automatic void mon(int inst, logic h, logic m, int score, int combo);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_evt inst=%0d actual hit=%0b miss=%0b score=%0d combo=%0d required no pulse",
               inst, h, m, score, combo);
      return;
    end
    e = exp_q.pop_front();
    if (e.inst != inst || h !== e.is_hit || m !== !e.is_hit || score != e.score || combo != e.combo) begin
      errors++;
      $display("FAIL evt_%s actual inst=%0d hit=%0b miss=%0b score=%0d combo=%0d required inst=%0d hit=%0b miss=%0b score=%0d combo=%0d",
               e.tag, inst, h, m, score, combo, e.inst, e.is_hit, !e.is_hit, e.score, e.combo);
    end
  endfunction

  // Monitor: every hit/miss pulse consumes one expected event
  always @(negedge clk) begin
    if (a_hit | a_miss) mon(0, a_hit, a_miss, int'(a_score), int'(a_combo));
    if (b_hit | b_miss) mon(1, b_hit, b_miss, int'(b_score), int'(b_combo));
    if (c_hit | c_miss) mon(2, c_hit, c_miss, int'(c_score), int'(c_combo));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One beat: low settle time, rise (optionally with a key press), outputs updated on return
  task automatic step(input int i, input bit n, input bit k);
    cyc(3);
    note[i] = n;
    beat[i] = 1'b1;
    if (k) key[i] = 1'b1;
    cyc(3);
    note[i] = 1'b0;
    beat[i] = 1'b0;
    key[i]  = 1'b0;
  endtask

  task automatic press(input int i);
    cyc(3);
    key[i] = 1'b1;
    cyc(3);
    key[i] = 1'b0;
  endtask

  task automatic pulse_start(input int i);
    strt[i] = 1'b1;
    cyc(1);
    strt[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      beat[i] = 1'b0; strt[i] = 1'b0; note[i] = 1'b0; key[i] = 1'b0;
    end

    // Reset with beat/key already high: no step or key edge, state idle
    resetn = 1'b0;
    beat[0] = 1'b1; key[0] = 1'b1; note[0] = 1'b1;
    cyc(2);
    chk("reset_state", 32'(a_state), 32'd0);
    chk("reset_lane", 32'(a_lane), 32'd0);
    chk("reset_hit_miss", {30'd0, a_hit, a_miss}, 32'd0);
    resetn = 1'b1;
    cyc(10);
    chk("high_at_release_state", 32'(a_state), 32'd0);

    // Same again but enter PLAY at once so a spurious step/key would be visible
    resetn = 1'b0;
    strt[0] = 1'b1;
    cyc(2);
    resetn = 1'b1;
    cyc(1);
    strt[0] = 1'b0;
    chk("start_to_play", 32'(a_state), 32'd1);
    cyc(9);
    chk("no_spurious_step", 32'(a_lane), 32'd0);
    beat[0] = 1'b0; key[0] = 1'b0; note[0] = 1'b0;

    // Note scrolls the full lane and leaves unhit
    step(0, 1'b1, 1'b0);
    chk("note_enters_msb", 32'(a_lane), 32'h8000);
    for (int s = 2; s <= 16; s++) step(0, 1'b0, 1'b0);
    chk("note_at_hit_zone", 32'(a_lane), 32'h0001);
    expect_evt(0, 1'b0, 0, 0, "scroll_out_miss");
    step(0, 1'b0, 1'b0);
    chk("lane_empty_after_miss", 32'(a_lane), 32'd0);
    chk("score_after_miss", 32'(a_score), 32'd0);

    // Hit latency: key rise to hit pulse is exactly three clocks
    step(0, 1'b1, 1'b0);
    for (int s = 19; s <= 33; s++) step(0, 1'b0, 1'b0);
    chk("note_ready_for_hit", 32'(a_lane), 32'h0001);
    expect_evt(0, 1'b1, 1, 1, "first_hit");
    cyc(3);
    key[0] = 1'b1;
    cyc(2);
    chk("hit_not_early", 32'(a_hit), 32'd0);
    cyc(1);
    chk("hit_at_3_cycles", 32'(a_hit), 32'd1);
    chk("hit_clears_zone", 32'(a_lane), 32'd0);
    chk("score_after_hit", 32'(a_score), 32'd1);
    chk("combo_after_hit", 32'(a_combo), 32'd1);
    key[0] = 1'b0;
    step(0, 1'b0, 1'b0);
    chk("no_miss_after_hit", 32'(a_combo), 32'd1);

    // Key and step in the same cycle with a note in the hit zone
    step(0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0);
    for (int s = 37; s <= 50; s++) step(0, 1'b0, 1'b0);
    chk("two_notes_at_zone", 32'(a_lane), 32'h0003);
    expect_evt(0, 1'b1, 2, 2, "simul_hit");
    step(0, 1'b0, 1'b1);
    chk("simul_lane_shifted", 32'(a_lane), 32'h0001);
    expect_evt(0, 1'b0, 2, 0, "second_note_missed");
    step(0, 1'b0, 1'b0);
    chk("lane_after_second_miss", 32'(a_lane), 32'd0);
    expect_evt(0, 1'b0, 2, 0, "wrong_press_a");
    press(0);
    chk("score_kept_after_wrong", 32'(a_score), 32'd2);

    // Run to the end of the 64-step song
    for (int s = 53; s <= 63; s++) step(0, 1'b0, 1'b0);
    chk("still_play_at_63", 32'(a_state), 32'd1);
    step(0, 1'b0, 1'b0);
    chk("done_at_64", 32'(a_state), 32'd2);
    pulse_start(0);
    chk("done_to_idle", 32'(a_state), 32'd0);
    chk("idle_score_clear", 32'(a_score), 32'd0);

    // Two-bit score saturates at 3
    pulse_start(1);
    chk("b_play", 32'(b_state), 32'd1);
    step(1, 1'b1, 1'b0);
    for (int h = 1; h <= 5; h++) begin
      step(1, 1'b1, 1'b0);
      expect_evt(1, 1'b1, (h < 3) ? h : 3, (h < 3) ? h : 3, $sformatf("sat_hit%0d", h));
      press(1);
    end
    chk("b_score_sat", 32'(b_score), 32'd3);
    chk("b_combo_sat", 32'(b_combo), 32'd3);
    expect_evt(1, 1'b0, 3, 0, "wrong_press_b");
    press(1);
    chk("b_combo_reset", 32'(b_combo), 32'd0);
    chk("b_score_kept", 32'(b_score), 32'd3);

    // Four-step song ends, then DONE ignores keys and steps
    pulse_start(2);
    step(2, 1'b1, 1'b0);
    step(2, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0);
    chk("c_play_at_3", 32'(c_state), 32'd1);
    step(2, 1'b0, 1'b0);
    chk("c_done_at_4", 32'(c_state), 32'd2);
    chk("c_lane_at_done", 32'(c_lane), 32'h1);
    press(2);
    step(2, 1'b1, 1'b0);
    chk("c_lane_frozen", 32'(c_lane), 32'h1);
    chk("c_score_frozen", 32'(c_score), 32'd0);
    chk("c_still_done", 32'(c_state), 32'd2);
    pulse_start(2);
    chk("c_done_to_idle", 32'(c_state), 32'd0);
    chk("c_idle_lane", 32'(c_lane), 32'd0);

    cyc(5);
    chk("pending_events", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
